// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the M-extension operations
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op;

    // Sequencer states of the iterative unit
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state;

    // funct7 value that selects the M extension in the decoder
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    // Divide and remainder ops all have funct3[2] set
    function automatic logic op_is_div(input muldiv_op op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_srca_signed(input muldiv_op op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) ||
               (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM
    function automatic logic op_srcb_signed(input muldiv_op op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Final correction stage: turns the unsigned magnitude product or
// quotient/remainder into the architectural result, including the
// divide-by-zero and signed-overflow special cases.
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_op               op,
    input  logic [2*WIDTH-1:0]     acc,
    input  logic                   a_neg,
    input  logic                   b_neg,
    input  logic                   div_zero,
    input  logic                   overflow,
    input  logic [WIDTH-1:0]       srca,
    output logic [WIDTH-1:0]       result
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Sign-correct the magnitudes and pick the field the op returns
    always_comb begin
        product = (a_neg ^ b_neg) ? (~acc + 1'b1) : acc;
        quot    = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        result  = '0;
        case (op)
            MUL: result = product[WIDTH-1:0];
            MULH, MULHSU, MULHU: result = product[2*WIDTH-1:WIDTH];
            DIV, DIVU: begin
                if (div_zero) begin
                    result = '1;
                end else if (overflow) begin
                    result = MIN_NEG;
                end else begin
                    result = (a_neg ^ b_neg) ? (~quot + 1'b1) : quot;
                end
            end
            REM, REMU: begin
                if (div_zero) begin
                    result = srca;
                end else if (overflow) begin
                    result = '0;
                end else begin
                    result = a_neg ? (~rem + 1'b1) : rem;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. A radix-2 shift-add multiplier and
// a restoring divider share one double-width accumulator; every operation
// takes exactly WIDTH iterations regardless of operand values.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               flush,
    input  logic [2:0]         funct3,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state          state_q;
    logic [CNTW-1:0]      counter_q;
    muldiv_op             op_q;
    logic                 a_neg_q;
    logic                 b_neg_q;
    logic                 div_zero_q;
    logic                 overflow_q;
    logic [WIDTH-1:0]     srca_q;
    logic [WIDTH-1:0]     opb_q;
    logic [2*WIDTH-1:0]   acc_q;

    muldiv_op             op_in;
    logic                 a_neg_in;
    logic                 b_neg_in;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_shift;
    logic                 div_fits;
    logic [WIDTH-1:0]     rem_diff;
    logic [2*WIDTH-1:0]   div_next;

    logic [WIDTH-1:0]     fix_result;

    // Decode the incoming request into sign flags and operand magnitudes
    always_comb begin
        op_in    = muldiv_op'(funct3);
        a_neg_in = op_srca_signed(op_in) & srca[WIDTH-1];
        b_neg_in = op_srcb_signed(op_in) & srcb[WIDTH-1];
        mag_a    = a_neg_in ? (~srca + 1'b1) : srca;
        mag_b    = b_neg_in ? (~srcb + 1'b1) : srcb;
    end

    // One multiply step and one restoring-divide step from the accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_fits  = (rem_shift >= {1'b0, opb_q});
        rem_diff  = rem_shift[WIDTH-1:0] - opb_q;
        div_next  = div_fits ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {acc_q[2*WIDTH-2:0], 1'b0};
    end

    muldiv_fixup #(
        .WIDTH    (WIDTH)
    ) u_fixup (
        .op       (op_q),
        .acc      (acc_q),
        .a_neg    (a_neg_q),
        .b_neg    (b_neg_q),
        .div_zero (div_zero_q),
        .overflow (overflow_q),
        .srca     (srca_q),
        .result   (fix_result)
    );

    // Sequencer and iteration datapath; flush overrides every transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            op_q       <= MUL;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            srca_q     <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q       <= op_in;
                        a_neg_q    <= a_neg_in;
                        b_neg_q    <= b_neg_in;
                        srca_q     <= srca;
                        div_zero_q <= (srcb == '0);
                        overflow_q <= op_srca_signed(op_in) & op_is_div(op_in) &
                                      (srca == MIN_NEG) & (srcb == '1);
                        if (op_is_div(op_in)) begin
                            opb_q <= mag_b;
                            acc_q <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            opb_q <= mag_a;
                            acc_q <= {{WIDTH{1'b0}}, mag_b};
                        end
                        counter_q <= '0;
                        busy      <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    acc_q     <= op_is_div(op_q) ? div_next : mul_next;
                    counter_q <= counter_q + CNTW'(1);
                    if (counter_q == CNTW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result  <= fix_result;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit: stimulus pushes hand-computed
// results, a monitor pops and compares whenever done is seen.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              start  = 1'b0;
    logic              flush  = 1'b0;
    logic [2:0]        funct3 = 3'b000;
    logic [WIDTH-1:0]  srca   = '0;
    logic [WIDTH-1:0]  srcb   = '0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] value;
    } expect_t;

    expect_t          sb_q[$];
    logic [WIDTH-1:0] last_result = '0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .srca   (srca),
        .srcb   (srcb),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        expect_t e;
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 required no pending op");
            end else begin
                e = sb_q.pop_front();
                checkOutput(e.name, result, e.value);
            end
        end
    end

    // mode 0: plain op; 1: extra start pulse at edge 10; 2: flush at edge 20;
    // 3: asynchronous reset during cycle 15
    task automatic applyStimulus(input muldiv_op op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                                 input string name, input int mode);
        int k;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        start  = 1'b1;
        funct3 = op;
        srca   = a;
        srcb   = b;
        if (mode < 2) sb_q.push_back('{name: name, value: exp});
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom_range(7, 0));
        srca   = $urandom;
        srcb   = $urandom;
        seen    = 1'b0;
        busy_ok = 1'b1;
        k       = 0;
        while (!seen && k <= WIDTH + 6) begin
            @(negedge clk);
            if (mode == 1 && k == 9) begin
                start  = 1'b1;
                funct3 = MUL;
                srca   = 32'd11;
                srcb   = 32'd13;
            end
            if (mode == 1 && k == 10) start = 1'b0;
            if (mode == 2 && k == 19) flush = 1'b1;
            if (mode == 2 && k == 20) begin
                flush = 1'b0;
                checkOutput({name, "_busy_after_flush"}, 32'(busy), 32'd0);
            end
            if (mode == 3 && k == 14) begin
                #2;
                reset = 1'b0;
                #1;
                checkOutput({name, "_rst_busy"}, 32'(busy), 32'd0);
                checkOutput({name, "_rst_done"}, 32'(done), 32'd0);
                checkOutput({name, "_rst_result"}, result, 32'd0);
                last_result = '0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (done) begin
                seen = 1'b1;
                busy_ok &= (busy === 1'b0);
            end else begin
                busy_ok &= (busy === (k <= WIDTH));
                k++;
            end
        end
        if (mode == 2) begin
            checkOutput({name, "_no_done"}, 32'(seen), 32'd0);
            checkOutput({name, "_result_held"}, result, last_result);
            return;
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_latency"}, 32'(k), 32'(WIDTH + 1));
        checkOutput({name, "_busy_window"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
        last_result = exp;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3",    0);
        applyStimulus(MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min",    0);
        applyStimulus(MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulhu_min",   0);
        applyStimulus(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1",   0);
        applyStimulus(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2",    0);
        applyStimulus(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2",    0);
        applyStimulus(DIVU,   32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, "divu_16",     0);
        applyStimulus(REMU,   32'hFFFF_FFFF,  32'h10,        32'h0000_000F, "remu_16",     0);
        applyStimulus(DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, "div_by_0",    0);
        applyStimulus(REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, "rem_by_0",    0);
        applyStimulus(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",     0);
        applyStimulus(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf",     0);
        applyStimulus(MUL,    32'd6,          32'd7,         32'd42,        "mul_ign_start", 1);
        applyStimulus(DIVU,   32'd100,        32'd7,         32'd14,        "divu_flush",  2);
        applyStimulus(MUL,    32'd9,          32'd9,         32'd81,        "mul_reset",   3);
        applyStimulus(MUL,    32'd3,          32'd4,         32'd12,        "mul_3_4",     0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit. It sits downstream of the multicycle controller and beside the ALU in the datapath.
- The controller issues a one-cycle start with operands and funct3. It holds in its execute state while busy=1 and writes result back in ALUWB when done pulses.
- Radix-2 shift-add multiplier and restoring divider share one accumulator. Latency is fixed and independent of operand values.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and at least 4.
- CNTW, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  synchronous abort; returns to IDLE, no done
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srca  input  WIDTH  rs1 operand (multiplicand / dividend)
- srcb  input  WIDTH  rs2 operand (multiplier / divisor)
- busy  output  1  high from the cycle after start is accepted through the FIX state
- done  output  1  one-cycle pulse; result valid in this cycle
- result  output  WIDTH  registered result; holds until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous) forces state=IDLE, busy=0, done=0, result=0, counter=0 and all internal accumulators to 0. Reset mid-operation discards the operation and produces no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 & flush=0 latches funct3, the operand magnitudes and the sign flags, then goes to CALC with counter=0.
  - Signed operand per op: MUL/MULH/DIV/REM both; MULHSU srca only; MULHU/DIVU/REMU none.
- CALC, one iteration per cycle, counter increments each cycle, exits to FIX after exactly WIDTH cycles:
  - Multiply: 2*WIDTH product register; add the multiplicand when the multiplier LSB=1, then shift right.
  - Divide: restoring; shift {rem,quot} left, trial-subtract the divisor, set the quotient bit when there is no borrow.
- FIX (1 cycle):
  - Negate the product when the operand signs differ. MUL returns the low WIDTH bits, the others the high WIDTH bits.
  - Quotient is negated when the operand signs differ. Remainder takes the dividend's sign.
  - Divisor==0: quotient = all ones for both DIV and DIVU. REM/REMU return srca unchanged. Sign fixup is not applied to these.
  - Signed overflow (srca = -2^(WIDTH-1), srcb = -1): DIV returns -2^(WIDTH-1), REM returns 0.
  - result is registered at the end of FIX.
- DONE (1 cycle): done=1, busy=0, then IDLE. start is not accepted in DONE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles. The earliest next start is accepted at edge WIDTH+3.
- start while busy or in DONE is ignored; no queuing.
- flush has priority over start and over all state transitions. It sets state to IDLE and busy to 0, leaves result unchanged, and suppresses done.
- Simultaneous flush and start in IDLE: start is ignored.
- Operands and funct3 are not required stable after the start cycle; only the latched copies are used.

Decomposition:
- Shared package muldiv_pkg: typedef enum logic[2:0] muldiv_op (names per the funct3 list), typedef enum logic[1:0] muldiv_state (IDLE, CALC, FIX, DONE), constant MULDIV_FUNCT7 = 7'b0000001.
- One sub-module, muldiv_fixup: combinational sign correction plus the divide-by-zero and overflow overrides.
- The FSM and iteration datapath stay in muldiv_unit.

Test Plan:
- MUL srca=7, srcb=-3 (0xFFFFFFFD), start at cycle 0 -> busy cycles 1..33, done=1 at cycle 34 only, result=0xFFFFFFEB.
- MULH srca=0x80000000, srcb=0x80000000 -> result=0x40000000. MULHU same operands -> 0x40000000. MULHSU srca=-1, srcb=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF. REMU same operands -> 0xF.
- DIV srca=5, srcb=0 -> 0xFFFFFFFF. REM srca=-5, srcb=0 -> 0xFFFFFFFB. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- start pulsed again at cycle 10 during busy -> ignored, single done at cycle 34. flush at cycle 20 -> busy=0 at cycle 21, no done, result keeps its previous value.
- reset=0 asserted asynchronously at cycle 15 mid-CALC -> busy=0, done=0, result=0 immediately. A new MUL 3*4 after release -> result=12 after 34 cycles.
